vis_bank_accumulator: RTL and testbench

//   Parametrised successor to the correlator's output-bank logic. Sits after the correlator daisy-chain.

---
 rtl/vis_bank_accumulator_if.sv | 26 ++
 rtl/vis_bank_accumulator.sv | 114 +++++++++++
 tb/tb_vis_bank_accumulator.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/vis_bank_accumulator_if.sv
// vis_bank_accumulator_if: input partial-sum stream, output visibility stream and status
interface vis_bank_accumulator_if #(
  parameter int SBITS = 6,
  parameter int ACCUM = 36,
  parameter int BBITS = 1
);
  logic signed [SBITS-1:0] s_revis;
  logic signed [SBITS-1:0] s_imvis;
  logic                    s_valid;
  logic                    s_ready;
  logic signed [ACCUM-1:0] m_revis;
  logic signed [ACCUM-1:0] m_imvis;
  logic                    m_valid;
  logic                    m_ready;
  logic                    m_last;
  logic [BBITS-1:0]        m_bank;
  logic                    overflow;
  modport master (
    output s_revis, s_imvis, s_valid, m_ready,
    input  s_ready, m_revis, m_imvis, m_valid, m_last, m_bank, overflow
  );
  modport slave (
    input  s_revis, s_imvis, s_valid, m_ready,
    output s_ready, m_revis, m_imvis, m_valid, m_last, m_bank, overflow
  );
endinterface

// File: rtl/vis_bank_accumulator.sv
// vis_bank_accumulator: integrates NSUMS sweeps of partial-sum visibilities into a ring of banks streamed out over AXI4-Stream
module vis_bank_accumulator #(
  parameter int SBITS = 6,
  parameter int ACCUM = 36,
  parameter int TOTAL = 540,
  parameter int ABITS = 10,
  parameter int NSUMS = 1024,
  parameter int NBITS = 10,
  parameter int BANKS = 2,
  parameter int BBITS = 1,
  parameter int SATUR = 0
) (
  input logic clock_i,
  input logic reset_i,
  input logic enable_i,
  vis_bank_accumulator_if.slave bus
);
  logic signed [ACCUM-1:0] sum_re [BANKS][TOTAL];
  logic signed [ACCUM-1:0] sum_im [BANKS][TOTAL];
  logic [ABITS-1:0] widx_q, widx_d, ridx_q, ridx_d, ri;
  logic [NBITS-1:0] sweep_q, sweep_d;
  logic [BBITS-1:0] wbank_q, wbank_d, rbank_q, rbank_d, bank_q, bank_d;
  logic [BANKS-1:0] full_q, full_d, full_f;
  logic signed [ACCUM-1:0] re_q, re_d, im_q, im_d, re_new, im_new, base_re, base_im;
  logic valid_q, valid_d, last_q, last_d, ovf_q, ovf_d;
  logic accept, wlast, commit, last_hs, load, clamp_re, clamp_im;

  function automatic logic [ACCUM:0] add(input logic [ACCUM-1:0] b, input logic [SBITS-1:0] x);
    return {b[ACCUM-1], b} + {{(ACCUM+1-SBITS){x[SBITS-1]}}, x};
  endfunction

  // top bit of the result flags a clamp; the low ACCUM bits are the stored value
  function automatic logic [ACCUM:0] sat(input logic [ACCUM:0] s);
    logic ov;
    ov = (SATUR != 0) && (s[ACCUM] != s[ACCUM-1]);
    return {ov, ov ? {s[ACCUM], {(ACCUM-1){~s[ACCUM]}}} : s[ACCUM-1:0]};
  endfunction

  function automatic logic [BBITS-1:0] nxt(input logic [BBITS-1:0] b);
    return b == BBITS'(BANKS-1) ? '0 : b + BBITS'(1);
  endfunction

  assign bus.s_ready  = enable_i & ~full_q[wbank_q] & ~reset_i;
  assign bus.m_revis  = re_q;
  assign bus.m_imvis  = im_q;
  assign bus.m_valid  = valid_q;
  assign bus.m_last   = last_q;
  assign bus.m_bank   = bank_q;
  assign bus.overflow = ovf_q;

  // write-side counters, bank commit/free bookkeeping and output-stage load
  always_comb begin
    accept = bus.s_valid & bus.s_ready;
    wlast = widx_q == ABITS'(TOTAL-1);
    commit = accept & wlast & (sweep_q == NBITS'(NSUMS-1));
    base_re = sweep_q == '0 ? '0 : sum_re[wbank_q][widx_q];
    base_im = sweep_q == '0 ? '0 : sum_im[wbank_q][widx_q];
    {clamp_re, re_new} = sat(add(base_re, bus.s_revis));
    {clamp_im, im_new} = sat(add(base_im, bus.s_imvis));
    widx_d = accept ? (wlast ? '0 : widx_q + ABITS'(1)) : widx_q;
    sweep_d = (accept & wlast) ? (commit ? '0 : sweep_q + NBITS'(1)) : sweep_q;
    wbank_d = commit ? nxt(wbank_q) : wbank_q;
    last_hs = valid_q & bus.m_ready & last_q;
    rbank_d = last_hs ? nxt(rbank_q) : rbank_q;
    full_f = full_q & ~(BANKS'(last_hs) << rbank_q);
    full_d = full_f | (BANKS'(commit) << wbank_q);
    ri = last_hs ? '0 : ridx_q;
    load = (~valid_q | bus.m_ready) & full_f[rbank_d];
    ridx_d = load ? (ri == ABITS'(TOTAL-1) ? '0 : ri + ABITS'(1)) : ri;
    valid_d = load | (valid_q & ~bus.m_ready);
    last_d = load ? (ri == ABITS'(TOTAL-1)) : (last_q & valid_d);
    re_d = load ? sum_re[rbank_d][ri] : re_q;
    im_d = load ? sum_im[rbank_d][ri] : im_q;
    bank_d = load ? rbank_d : bank_q;
    ovf_d = ovf_q | (accept & (clamp_re | clamp_im));
  end

  // control state; reset abandons any partial frame and un-streamed banks
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      widx_q <= '0;
      sweep_q <= '0;
      wbank_q <= '0;
      rbank_q <= '0;
      ridx_q <= '0;
      full_q <= '0;
      valid_q <= 1'b0;
      last_q <= 1'b0;
      bank_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      widx_q <= widx_d;
      sweep_q <= sweep_d;
      wbank_q <= wbank_d;
      rbank_q <= rbank_d;
      ridx_q <= ridx_d;
      full_q <= full_d;
      valid_q <= valid_d;
      last_q <= last_d;
      bank_q <= bank_d;
      ovf_q <= ovf_d;
    end
  end

  // sum RAM read-modify-write and output data register, neither cleared by reset
  always_ff @(posedge clock_i) begin
    if (accept) begin
      sum_re[wbank_q][widx_q] <= re_new;
      sum_im[wbank_q][widx_q] <= im_new;
    end
    re_q <= re_d;
    im_q <= im_d;
  end
endmodule

// File: tb/tb_vis_bank_accumulator.sv
// tb_vis_bank_accumulator: directed vectors for the bank accumulator, plus saturating and wrapping variants
module tb_vis_bank_accumulator;
  logic clk = 1'b0, rst = 1'b1, en = 1'b1, rdy = 1'b1, tog = 1'b0, tog_en = 1'b0;
  logic signed [5:0] sre = '0, sim = '0;
  logic sval = 1'b0;
  int nvec = 0, nfail = 0;

  typedef struct { int re; int im; int exp_re; int exp_im; bit exp_last; } vec_t;
  typedef struct { int re; int im; bit last; int bank; } beat_t;
  beat_t outq[$];
  beat_t prev;
  bit pstall = 1'b0;

  always #5 clk = ~clk;

  vis_bank_accumulator_if #(.SBITS(6), .ACCUM(12), .BBITS(1)) ifm ();
  vis_bank_accumulator_if #(.SBITS(6), .ACCUM(7), .BBITS(1)) ifs ();
  vis_bank_accumulator_if #(.SBITS(6), .ACCUM(7), .BBITS(1)) ifw ();

  assign ifm.m_ready = tog_en ? tog : rdy;
  assign ifs.s_revis = sre;
  assign ifs.s_imvis = sim;
  assign ifs.s_valid = sval;
  assign ifs.m_ready = 1'b1;
  assign ifw.s_revis = sre;
  assign ifw.s_imvis = sim;
  assign ifw.s_valid = sval;
  assign ifw.m_ready = 1'b1;

  vis_bank_accumulator #(.SBITS(6), .ACCUM(12), .TOTAL(4), .ABITS(2), .NSUMS(3), .NBITS(2),
    .BANKS(2), .BBITS(1), .SATUR(0)) dut (.clock_i(clk), .reset_i(rst), .enable_i(en), .bus(ifm));
  vis_bank_accumulator #(.SBITS(6), .ACCUM(7), .TOTAL(4), .ABITS(2), .NSUMS(3), .NBITS(2),
    .BANKS(2), .BBITS(1), .SATUR(1)) dut_sat (.clock_i(clk), .reset_i(rst), .enable_i(1'b1), .bus(ifs));
  vis_bank_accumulator #(.SBITS(6), .ACCUM(7), .TOTAL(4), .ABITS(2), .NSUMS(3), .NBITS(2),
    .BANKS(2), .BBITS(1), .SATUR(0)) dut_wrap (.clock_i(clk), .reset_i(rst), .enable_i(1'b1), .bus(ifw));

  task automatic chk(input string name, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nfail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic expire(input string name);
    nvec++;
    nfail++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  always @(negedge clk) tog = ~tog;

  // output monitor: logs every handshaken beat and checks stability while stalled
  always @(negedge clk) begin
    #2;
    if (pstall) begin
      chk("hold_valid", int'(ifm.m_valid), 1);
      chk("hold_re", int'(ifm.m_revis), prev.re);
      chk("hold_im", int'(ifm.m_imvis), prev.im);
      chk("hold_last", int'(ifm.m_last), int'(prev.last));
      chk("hold_bank", int'(ifm.m_bank), prev.bank);
    end
    if (ifm.m_valid && ifm.m_ready)
      outq.push_back('{int'(ifm.m_revis), int'(ifm.m_imvis), ifm.m_last, int'(ifm.m_bank)});
    pstall = ifm.m_valid && !ifm.m_ready && !rst;
    prev = '{int'(ifm.m_revis), int'(ifm.m_imvis), ifm.m_last, int'(ifm.m_bank)};
  end

  task automatic cyc(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input int re, input int im);
    int t = 0;
    ifm.s_revis = 6'(re);
    ifm.s_imvis = 6'(im);
    ifm.s_valid = 1'b1;
    #1;
    while (!ifm.s_ready && t < 200) begin
      @(negedge clk);
      #1;
      t++;
    end
    if (!ifm.s_ready) expire("send");
    else @(negedge clk);
    ifm.s_valid = 1'b0;
  endtask

  task automatic send_frame(input int f, input int gap);
    for (int sw = 0; sw < 3; sw++)
      for (int k = 0; k < 4; k++) begin
        if (gap != 0) cyc(int'($urandom_range(0, 2)));
        send(k + 1 + 4 * f, -(f + 1));
      end
  endtask

  task automatic wait_beats(input int n);
    int t = 0;
    while (outq.size() < n && t < 300) begin
      cyc();
      t++;
    end
    if (outq.size() < n) expire("wait_beats");
  endtask

  task automatic check_frames(input int nf, input int f0, input int b0);
    chk("beat_count", outq.size(), nf * 4);
    for (int i = 0; i < nf * 4 && i < outq.size(); i++) begin
      chk("beat_re", outq[i].re, 3 * ((i % 4) + 1 + 4 * (f0 + i / 4)));
      chk("beat_im", outq[i].im, -3 * (f0 + i / 4 + 1));
      chk("beat_last", int'(outq[i].last), int'(i % 4 == 3));
      chk("beat_bank", outq[i].bank, (b0 + i / 4) % 2);
    end
  endtask

  initial begin
    vec_t tab[4];
    int seen;
    tab[0] = '{1, -1, 3, -3, 1'b0};
    tab[1] = '{2, -2, 6, -6, 1'b0};
    tab[2] = '{3, -3, 9, -9, 1'b0};
    tab[3] = '{4, -4, 12, -12, 1'b1};
    ifm.s_valid = 1'b0;
    ifm.s_revis = '0;
    ifm.s_imvis = '0;
    cyc(2);
    rst = 1'b0;
    #1;
    chk("rst_valid", int'(ifm.m_valid), 0);
    chk("rst_last", int'(ifm.m_last), 0);
    chk("rst_bank", int'(ifm.m_bank), 0);
    chk("rst_ovf", int'(ifm.overflow), 0);
    chk("rst_ready", int'(ifm.s_ready), 1);
    chk("rst_sat_ovf", int'(ifs.overflow), 0);
    cyc();
    // saturating versus wrapping arithmetic on ACCUM=7
    for (int i = 0; i < 12; i++) begin
      sre = 6'sd31;
      sim = -6'sd31;
      sval = 1'b1;
      #1;
      chk("sat_ready", int'(ifs.s_ready), 1);
      @(negedge clk);
    end
    sval = 1'b0;
    seen = 0;
    for (int t = 0; t < 10 && seen < 4; t++) begin
      if (ifs.m_valid) begin
        chk("sat_re", int'(ifs.m_revis), 63);
        chk("sat_im", int'(ifs.m_imvis), -64);
        chk("wrap_re", int'(ifw.m_revis), -35);
        chk("wrap_im", int'(ifw.m_imvis), 35);
        seen++;
      end
      cyc();
    end
    chk("sat_beats", seen, 4);
    chk("sat_ovf", int'(ifs.overflow), 1);
    chk("wrap_ovf", int'(ifw.overflow), 0);
    // three sweeps with the table stimulus, always ready
    outq.delete();
    for (int sw = 0; sw < 3; sw++)
      for (int k = 0; k < 4; k++) send(tab[k].re, tab[k].im);
    chk("lat_valid0", int'(ifm.m_valid), 0);
    cyc();
    chk("lat_valid1", int'(ifm.m_valid), 1);
    chk("lat_re", int'(ifm.m_revis), 3);
    wait_beats(4);
    cyc(3);
    chk("t1_count", outq.size(), 4);
    for (int k = 0; k < 4 && k < outq.size(); k++) begin
      chk("t1_re", outq[k].re, tab[k].exp_re);
      chk("t1_im", outq[k].im, tab[k].exp_im);
      chk("t1_last", int'(outq[k].last), int'(tab[k].exp_last));
      chk("t1_bank", outq[k].bank, 0);
    end
    // same frame with a five-cycle enable drop mid-sweep, lands in bank 1
    outq.delete();
    for (int sw = 0; sw < 3; sw++)
      for (int k = 0; k < 4; k++) begin
        if (sw == 1 && k == 2) begin
          en = 1'b0;
          for (int p = 0; p < 5; p++) begin
            #1;
            chk("pause_ready", int'(ifm.s_ready), 0);
            cyc();
          end
          en = 1'b1;
        end
        send(tab[k].re, tab[k].im);
      end
    wait_beats(4);
    cyc(3);
    chk("t6_count", outq.size(), 4);
    for (int k = 0; k < 4 && k < outq.size(); k++) begin
      chk("t6_re", outq[k].re, tab[k].exp_re);
      chk("t6_im", outq[k].im, tab[k].exp_im);
      chk("t6_last", int'(outq[k].last), int'(tab[k].exp_last));
      chk("t6_bank", outq[k].bank, 1);
    end
    // both banks full under back-pressure, then release
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    outq.delete();
    rdy = 1'b0;
    send_frame(0, 0);
    send_frame(1, 0);
    #1;
    chk("full_ready", int'(ifm.s_ready), 0);
    chk("full_valid", int'(ifm.m_valid), 1);
    chk("full_re", int'(ifm.m_revis), 3);
    chk("full_bank", int'(ifm.m_bank), 0);
    cyc(4);
    #1;
    chk("full_ready_hold", int'(ifm.s_ready), 0);
    cyc();
    rdy = 1'b1;
    send_frame(2, 0);
    wait_beats(12);
    cyc(4);
    check_frames(3, 0, 0);
    // reset while bank 0 is stalled mid-stream and bank 1 is half written
    outq.delete();
    rdy = 1'b0;
    send_frame(0, 0);
    for (int i = 0; i < 6; i++) send(20, 20);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    #1;
    chk("rst4_valid", int'(ifm.m_valid), 0);
    chk("rst4_last", int'(ifm.m_last), 0);
    chk("rst4_bank", int'(ifm.m_bank), 0);
    chk("rst4_ready", int'(ifm.s_ready), 1);
    cyc();
    rdy = 1'b1;
    outq.delete();
    send_frame(1, 0);
    wait_beats(4);
    cyc(6);
    check_frames(1, 1, 0);
    // alternating m_ready with random input gaps
    outq.delete();
    tog_en = 1'b1;
    send_frame(2, 1);
    send_frame(3, 1);
    wait_beats(8);
    tog_en = 1'b0;
    cyc(4);
    check_frames(2, 2, 1);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
